fft_mem_sched: RTL and testbench

In-place, memory-based 64-point radix-2 DIT FFT scheduler that feeds the team's combinational 2-point butterfly. It accepts one frame of natural-order complex samples and stores them in bit-reversed order. It then runs 6 stages × 32 butterflies, one per cycle, by presenting operand pairs and twiddles to the butterfly and writing the results back in place. Finally it streams the spectrum out in natural order. It sits between the sample source and the output consumer and wraps the butterfly, which is instantiated alongside it at the top level.

---
 rtl/fft_mem_sched_pkg.sv | 26 ++
 rtl/fft_twiddle_rom.sv | 51 +++++
 rtl/fft_mem_sched.sv | 160 ++++++++++++++++
 tb/tb_fft_mem_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_sched_pkg.sv
// Shared constants, state encoding and address helpers for the 64-point
// in-place radix-2 DIT FFT memory scheduler.
package fft_mem_sched_pkg;

  localparam int DATA_WID  = 16;
  localparam int WN_WID    = 16;
  localparam int ACC_LEN   = 14;
  localparam int N         = 64;
  localparam int LOG2N     = 6;
  localparam int ROM_DEPTH = N / 2;
  localparam int STG_W     = 3;
  localparam int BF_W      = LOG2N - 1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CALC   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle factors W64^k = cos(2*pi*k/64) - j*sin(2*pi*k/64), scaled by 2^ACC_LEN,
// for k = 0..31. Purely combinational lookup.
module fft_twiddle_rom
  import fft_mem_sched_pkg::*;
(
  input  logic [BF_W-1:0]          k,
  output logic signed [WN_WID-1:0] wn_re,
  output logic signed [WN_WID-1:0] wn_im
);

  always_comb begin
    wn_re = '0;
    wn_im = '0;
    case (k)
      5'd0:  begin wn_re =  16'sd16384; wn_im =  16'sd0;     end
      5'd1:  begin wn_re =  16'sd16305; wn_im = -16'sd1606;  end
      5'd2:  begin wn_re =  16'sd16069; wn_im = -16'sd3196;  end
      5'd3:  begin wn_re =  16'sd15679; wn_im = -16'sd4756;  end
      5'd4:  begin wn_re =  16'sd15137; wn_im = -16'sd6270;  end
      5'd5:  begin wn_re =  16'sd14449; wn_im = -16'sd7723;  end
      5'd6:  begin wn_re =  16'sd13623; wn_im = -16'sd9102;  end
      5'd7:  begin wn_re =  16'sd12665; wn_im = -16'sd10394; end
      5'd8:  begin wn_re =  16'sd11585; wn_im = -16'sd11585; end
      5'd9:  begin wn_re =  16'sd10394; wn_im = -16'sd12665; end
      5'd10: begin wn_re =  16'sd9102;  wn_im = -16'sd13623; end
      5'd11: begin wn_re =  16'sd7723;  wn_im = -16'sd14449; end
      5'd12: begin wn_re =  16'sd6270;  wn_im = -16'sd15137; end
      5'd13: begin wn_re =  16'sd4756;  wn_im = -16'sd15679; end
      5'd14: begin wn_re =  16'sd3196;  wn_im = -16'sd16069; end
      5'd15: begin wn_re =  16'sd1606;  wn_im = -16'sd16305; end
      5'd16: begin wn_re =  16'sd0;     wn_im = -16'sd16384; end
      5'd17: begin wn_re = -16'sd1606;  wn_im = -16'sd16305; end
      5'd18: begin wn_re = -16'sd3196;  wn_im = -16'sd16069; end
      5'd19: begin wn_re = -16'sd4756;  wn_im = -16'sd15679; end
      5'd20: begin wn_re = -16'sd6270;  wn_im = -16'sd15137; end
      5'd21: begin wn_re = -16'sd7723;  wn_im = -16'sd14449; end
      5'd22: begin wn_re = -16'sd9102;  wn_im = -16'sd13623; end
      5'd23: begin wn_re = -16'sd10394; wn_im = -16'sd12665; end
      5'd24: begin wn_re = -16'sd11585; wn_im = -16'sd11585; end
      5'd25: begin wn_re = -16'sd12665; wn_im = -16'sd10394; end
      5'd26: begin wn_re = -16'sd13623; wn_im = -16'sd9102;  end
      5'd27: begin wn_re = -16'sd14449; wn_im = -16'sd7723;  end
      5'd28: begin wn_re = -16'sd15137; wn_im = -16'sd6270;  end
      5'd29: begin wn_re = -16'sd15679; wn_im = -16'sd4756;  end
      5'd30: begin wn_re = -16'sd16069; wn_im = -16'sd3196;  end
      5'd31: begin wn_re = -16'sd16305; wn_im = -16'sd1606;  end
      default: begin wn_re = '0; wn_im = '0; end
    endcase
  end

endmodule

// File: rtl/fft_mem_sched.sv
// In-place 64-point radix-2 DIT FFT scheduler: loads a frame in bit-reversed order,
// drives one external butterfly per cycle for 6x32 cycles, then streams bins out.
module fft_mem_sched
  import fft_mem_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_WID-1:0] in_re,
  input  logic signed [DATA_WID-1:0] in_im,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_WID-1:0] out_re,
  output logic signed [DATA_WID-1:0] out_im,
  output logic                       out_last,
  output logic signed [DATA_WID-1:0] bf_re1_o,
  output logic signed [DATA_WID-1:0] bf_im1_o,
  output logic signed [DATA_WID-1:0] bf_re2_o,
  output logic signed [DATA_WID-1:0] bf_im2_o,
  output logic signed [WN_WID-1:0]   bf_wn_re_o,
  output logic signed [WN_WID-1:0]   bf_wn_im_o,
  input  logic signed [DATA_WID-1:0] bf_re1_i,
  input  logic signed [DATA_WID-1:0] bf_im1_i,
  input  logic signed [DATA_WID-1:0] bf_re2_i,
  input  logic signed [DATA_WID-1:0] bf_im2_i,
  output logic                       busy
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);
  localparam logic [BF_W-1:0]  LAST_BF  = BF_W'(N / 2 - 1);

  state_t                     r_state, w_state_nxt;
  logic [LOG2N-1:0]           r_in_cnt, w_in_cnt_nxt;
  logic [LOG2N-1:0]           r_out_cnt, w_out_cnt_nxt;
  logic [STG_W-1:0]           r_stg, w_stg_nxt;
  logic [BF_W-1:0]            r_bfly, w_bfly_nxt;
  logic signed [DATA_WID-1:0] r_mem_re [N];
  logic signed [DATA_WID-1:0] r_mem_im [N];

  logic                       w_calc, w_ld_fire, w_we1;
  logic [LOG2N-1:0]           w_bfly6, w_half, w_pos, w_a1, w_a2, w_wa1, w_ra1;
  logic [BF_W-1:0]            w_k;
  logic signed [DATA_WID-1:0] w_wd1_re, w_wd1_im;
  logic signed [DATA_WID-1:0] w_rd1_re, w_rd1_im, w_rd2_re, w_rd2_im;
  logic signed [WN_WID-1:0]   w_wn_re, w_wn_im;

  // Butterfly addressing: pairs are 'half' apart inside groups of 2*half.
  assign w_bfly6 = {1'b0, r_bfly};
  assign w_half  = LOG2N'(1) << r_stg;
  assign w_pos   = w_bfly6 & (w_half - LOG2N'(1));
  assign w_a1    = ((w_bfly6 >> r_stg) << (r_stg + STG_W'(1))) | w_pos;
  assign w_a2    = w_a1 | w_half;
  assign w_k     = w_pos[BF_W-1:0] << (STG_W'(5) - r_stg);

  assign w_calc    = (r_state == ST_CALC);
  assign w_ld_fire = in_valid && (r_state == ST_LOAD);
  assign w_we1     = w_ld_fire || w_calc;
  assign w_wa1     = w_calc ? w_a1 : bitrev6(r_in_cnt);
  assign w_wd1_re  = w_calc ? bf_re1_i : in_re;
  assign w_wd1_im  = w_calc ? bf_im1_i : in_im;
  // Port 1 doubles as the unload read port outside CALC.
  assign w_ra1     = w_calc ? w_a1 : r_out_cnt;
  assign w_rd1_re  = r_mem_re[w_ra1];
  assign w_rd1_im  = r_mem_im[w_ra1];
  assign w_rd2_re  = r_mem_re[w_a2];
  assign w_rd2_im  = r_mem_im[w_a2];

  fft_twiddle_rom u_rom (
    .k     (w_k),
    .wn_re (w_wn_re),
    .wn_im (w_wn_im)
  );

  always_ff @(posedge clk) begin
    if (w_we1) begin
      r_mem_re[w_wa1] <= w_wd1_re;
      r_mem_im[w_wa1] <= w_wd1_im;
    end
    if (w_calc) begin
      r_mem_re[w_a2] <= bf_re2_i;
      r_mem_im[w_a2] <= bf_im2_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_stg     <= '0;
      r_bfly    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_cnt  <= w_in_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
      r_stg     <= w_stg_nxt;
      r_bfly    <= w_bfly_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_in_cnt_nxt  = r_in_cnt;
    w_out_cnt_nxt = r_out_cnt;
    w_stg_nxt     = r_stg;
    w_bfly_nxt    = r_bfly;
    unique case (r_state)
      ST_LOAD: begin
        if (in_valid) begin
          w_in_cnt_nxt = r_in_cnt + 1'b1;
          if (r_in_cnt == LAST_IDX) begin
            w_state_nxt = ST_CALC;
            w_stg_nxt   = '0;
            w_bfly_nxt  = '0;
          end
        end
      end
      ST_CALC: begin
        w_bfly_nxt = r_bfly + 1'b1;
        if (r_bfly == LAST_BF) begin
          if (r_stg == LAST_STG) begin
            w_state_nxt   = ST_UNLOAD;
            w_stg_nxt     = '0;
            w_out_cnt_nxt = '0;
          end else begin
            w_stg_nxt = r_stg + 1'b1;
          end
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          w_out_cnt_nxt = r_out_cnt + 1'b1;
          if (r_out_cnt == LAST_IDX) begin
            w_state_nxt  = ST_LOAD;
            w_in_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready   = (r_state == ST_LOAD);
    busy       = (r_state == ST_CALC) || (r_state == ST_UNLOAD);
    out_valid  = (r_state == ST_UNLOAD);
    out_last   = (r_state == ST_UNLOAD) && (r_out_cnt == LAST_IDX);
    out_re     = (r_state == ST_UNLOAD) ? w_rd1_re : '0;
    out_im     = (r_state == ST_UNLOAD) ? w_rd1_im : '0;
    bf_re1_o   = w_calc ? w_rd1_re : '0;
    bf_im1_o   = w_calc ? w_rd1_im : '0;
    bf_re2_o   = w_calc ? w_rd2_re : '0;
    bf_im2_o   = w_calc ? w_rd2_im : '0;
    bf_wn_re_o = w_calc ? w_wn_re : '0;
    bf_wn_im_o = w_calc ? w_wn_im : '0;
  end

endmodule

// File: tb/tb_fft_mem_sched.sv
// Bench for fft_mem_sched: wraps it with a behavioural butterfly and checks whole
// frames against a textbook fixed-point FFT plus known-spectrum expectations.
module tb_fft_mem_sched;
  import fft_mem_sched_pkg::*;

  localparam int PAT_IMP  = 0;
  localparam int PAT_DC   = 1;
  localparam int PAT_TONE = 2;
  localparam int PAT_RAND = 3;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int pat;
    int amp;
    bit bp;
    bit hold;
    bit gaps;
    int e0;
    int e1;
    int eo;
    int tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DATA_WID-1:0] in_re, in_im, out_re, out_im;
  logic signed [DATA_WID-1:0] bf_re1_o, bf_im1_o, bf_re2_o, bf_im2_o;
  logic signed [DATA_WID-1:0] bf_re1_i, bf_im1_i, bf_re2_i, bf_im2_i;
  logic signed [WN_WID-1:0]   bf_wn_re_o, bf_wn_im_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int stim_re [N];
  int stim_im [N];
  int ref_re [N];
  int ref_im [N];
  vec_t tbl [8];

  always #5 clk = ~clk;

  fft_mem_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last),
    .bf_re1_o(bf_re1_o), .bf_im1_o(bf_im1_o), .bf_re2_o(bf_re2_o), .bf_im2_o(bf_im2_o),
    .bf_wn_re_o(bf_wn_re_o), .bf_wn_im_o(bf_wn_im_o),
    .bf_re1_i(bf_re1_i), .bf_im1_i(bf_im1_i), .bf_re2_i(bf_re2_i), .bf_im2_i(bf_im2_i),
    .busy(busy)
  );

  function automatic int wrap16(input longint v);
    logic signed [DATA_WID-1:0] s;
    s = v[DATA_WID-1:0];
    return int'(s);
  endfunction

  function automatic longint rnd_shift(input longint p);
    return (p + (longint'(1) <<< (ACC_LEN - 1))) >>> ACC_LEN;
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  function automatic int brev(input int a);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) if (((a >> i) & 1) != 0) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // Team butterfly: y1 = x1 + x2*W, y2 = x1 - x2*W, product rounded back by 2^ACC_LEN.
  always_comb begin
    longint tr, ti;
    tr = rnd_shift(longint'(bf_re2_o) * bf_wn_re_o - longint'(bf_im2_o) * bf_wn_im_o);
    ti = rnd_shift(longint'(bf_re2_o) * bf_wn_im_o + longint'(bf_im2_o) * bf_wn_re_o);
    bf_re1_i = DATA_WID'(longint'(bf_re1_o) + tr);
    bf_im1_i = DATA_WID'(longint'(bf_im1_o) + ti);
    bf_re2_i = DATA_WID'(longint'(bf_re1_o) - tr);
    bf_im2_i = DATA_WID'(longint'(bf_im1_o) - ti);
  end

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
    longint d;
    vec_cnt++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Textbook iterative Cooley-Tukey on a bit-reversed copy of the stimulus.
  task automatic model_fft();
    int ar [N];
    int ai [N];
    int m, h, wr, wi, x1r, x1i;
    longint tr, ti;
    real ang, sc;
    sc = real'(1 << ACC_LEN);
    for (int n = 0; n < N; n++) begin
      ar[brev(n)] = stim_re[n];
      ai[brev(n)] = stim_im[n];
    end
    for (int s = 1; s <= LOG2N; s++) begin
      m = 1 << s;
      h = m / 2;
      for (int j = 0; j < h; j++) begin
        ang = 2.0 * PI * real'(j) / real'(m);
        wr = rnd($cos(ang) * sc);
        wi = rnd(-$sin(ang) * sc);
        for (int k = 0; k < N; k += m) begin
          tr = rnd_shift(longint'(ar[k+j+h]) * wr - longint'(ai[k+j+h]) * wi);
          ti = rnd_shift(longint'(ar[k+j+h]) * wi + longint'(ai[k+j+h]) * wr);
          x1r = ar[k+j];
          x1i = ai[k+j];
          ar[k+j]   = wrap16(longint'(x1r) + tr);
          ai[k+j]   = wrap16(longint'(x1i) + ti);
          ar[k+j+h] = wrap16(longint'(x1r) - tr);
          ai[k+j+h] = wrap16(longint'(x1i) - ti);
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      ref_re[n] = ar[n];
      ref_im[n] = ai[n];
    end
  endtask

  task automatic gen_stim(input vec_t v);
    for (int n = 0; n < N; n++) begin
      case (v.pat)
        PAT_IMP:  begin stim_re[n] = (n == 0) ? v.amp : 0; stim_im[n] = 0; end
        PAT_DC:   begin stim_re[n] = v.amp; stim_im[n] = 0; end
        PAT_TONE: begin
          stim_re[n] = rnd(real'(v.amp) * $cos(2.0 * PI * real'(n) / real'(N)));
          stim_im[n] = 0;
        end
        default: begin
          stim_re[n] = int'($urandom_range(0, 2 * v.amp)) - v.amp;
          stim_im[n] = int'($urandom_range(0, 2 * v.amp)) - v.amp;
        end
      endcase
    end
  endtask

  // Called at a negedge in LOAD; returns at the negedge after sample 63 was accepted.
  task automatic load_frame(input bit gaps);
    int i, cyc;
    i = 0;
    cyc = 0;
    while (i < N && cyc < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_re = in_valid ? DATA_WID'(stim_re[i]) : DATA_WID'($urandom);
      in_im = in_valid ? DATA_WID'(stim_im[i]) : DATA_WID'($urandom);
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_count", i, N, 0);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int lat, nbin, cyc, exp_re;
    bit ctl_ok, held, rdy;
    logic signed [DATA_WID-1:0] pre, pim;
    gen_stim(v);
    model_fft();
    load_frame(v.gaps);
    lat = 1;
    ctl_ok = 1'b1;
    while (!out_valid && lat < 400) begin
      if (in_ready || !busy) ctl_ok = 1'b0;
      in_valid = v.hold;
      in_re = DATA_WID'($urandom);
      in_im = DATA_WID'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 193, 0);
    chk({tag, "_calc_ctl"}, ctl_ok, 1, 0);
    nbin = 0;
    cyc = 0;
    held = 1'b0;
    pre = '0;
    pim = '0;
    while (nbin < N && cyc < 2000) begin
      if (held) begin
        chk({tag, "_hold_valid"}, out_valid, 1, 0);
        chk({tag, "_hold_re"}, out_re, pre, 0);
        chk({tag, "_hold_im"}, out_im, pim, 0);
      end
      rdy = v.bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      out_ready = rdy;
      held = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          chk($sformatf("%s_bin%0d_re", tag, nbin), out_re, ref_re[nbin], 0);
          chk($sformatf("%s_bin%0d_im", tag, nbin), out_im, ref_im[nbin], 0);
          chk($sformatf("%s_last%0d", tag, nbin), out_last, (nbin == N - 1), 0);
          if (v.tol >= 0) begin
            exp_re = (nbin == 0) ? v.e0 : ((nbin == 1 || nbin == N - 1) ? v.e1 : v.eo);
            chk($sformatf("%s_spec%0d_re", tag, nbin), out_re, exp_re, v.tol);
            chk($sformatf("%s_spec%0d_im", tag, nbin), out_im, 0, v.tol);
          end
          nbin++;
        end else begin
          held = 1'b1;
          pre = out_re;
          pim = out_im;
        end
      end
      in_valid = v.hold;
      in_re = DATA_WID'($urandom);
      in_im = DATA_WID'($urandom);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_handshakes"}, nbin, N, 0);
    chk({tag, "_in_ready_after"}, in_ready, 1, 0);
    chk({tag, "_out_valid_after"}, out_valid, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1, 0);
    chk({tag, "_out_valid"}, out_valid, 0, 0);
    chk({tag, "_out_last"}, out_last, 0, 0);
    chk({tag, "_busy"}, busy, 0, 0);
    chk({tag, "_out_data"}, {out_re, out_im}, 0, 0);
    chk({tag, "_bf_data"}, {bf_re1_o, bf_im1_o, bf_re2_o, bf_im2_o}, 0, 0);
    chk({tag, "_bf_wn"}, {bf_wn_re_o, bf_wn_im_o}, 0, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{PAT_IMP,   100, 1'b0, 1'b0, 1'b0,   100,   100,  100, 0};
    tbl[1] = '{PAT_DC,     10, 1'b0, 1'b0, 1'b0,   640,     0,    0, 1};
    tbl[2] = '{PAT_TONE,  500, 1'b0, 1'b0, 1'b0,     0, 16000,    0, 8};
    tbl[3] = '{PAT_RAND,  500, 1'b1, 1'b1, 1'b1,     0,     0,    0, -1};
    tbl[4] = '{PAT_TONE,  500, 1'b1, 1'b1, 1'b0,     0, 16000,    0, 8};
    tbl[5] = '{PAT_RAND,  511, 1'b0, 1'b1, 1'b0,     0,     0,    0, -1};
    tbl[6] = '{PAT_IMP,  -300, 1'b1, 1'b0, 1'b0,  -300,  -300, -300, 0};
    tbl[7] = '{PAT_DC,     -7, 1'b0, 1'b0, 1'b1,  -448,     0,    0, 1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("idle");

    for (int t = 0; t < 8; t++) run_frame(tbl[t], $sformatf("frame%0d", t));

    // Reset asserted deep inside CALC must abandon the frame immediately.
    gen_stim(tbl[3]);
    load_frame(1'b0);
    repeat (100) @(negedge clk);
    chk("midcalc_busy", busy, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midcalc_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(tbl[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
